// File: rtl/axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_frame_arbiter
//
// Merges two AXI-Stream stereo audio sources (L beat, then R beat with last)
// onto one master stream. Ownership changes only on frame boundaries, and
// every change of owner passes through one IDLE cycle.
//   mode = 0 : fixed select. Source `sel` is forwarded. The other source is
//              drained and its beats are discarded.
//   mode = 1 : round-robin. Sources alternate per frame. The ungranted source
//              is stalled.
// While a source owns the bus, its valid/last/ready pass straight through
// with no added latency. Mute is sampled once per frame, at grant time.
//
// Ports
//   axis_clk, reset            clock, synchronous active-high reset
//   mode, sel, mute            arbitration mode, fixed-mode source, mute
//   s0_axis_*, s1_axis_*       source streams (data/valid/last in, ready out)
//   m_axis_*                   merged stream (data/valid/last out, ready in)
//   grant                      one-hot owner (00 = none)
//   frame_count                frames completed on the master port (wraps)
// -----------------------------------------------------------------------------
module axis_frame_arbiter #(
  parameter int DATA_WIDTH = 24,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  axis_clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  sel,
  input  logic                  mute,
  input  logic [DATA_WIDTH-1:0] s0_axis_data,
  input  logic                  s0_axis_valid,
  input  logic                  s0_axis_last,
  output logic                  s0_axis_ready,
  input  logic [DATA_WIDTH-1:0] s1_axis_data,
  input  logic                  s1_axis_valid,
  input  logic                  s1_axis_last,
  output logic                  s1_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic [1:0]            grant,
  output logic [FCNT_WIDTH-1:0] frame_count
);

  // The state encoding is also the one-hot grant value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t                state_reg, state_next;
  logic                  last_grant_reg, last_grant_next;  // 1 = source 1 was granted last
  logic                  mute_q_reg;
  logic [FCNT_WIDTH-1:0] frame_count_reg;
  logic [1:0]            in_frame_reg;

  logic [1:0]            src_valid, src_last, src_ready, eligible;
  logic [DATA_WIDTH-1:0] src_data [2];

  assign src_valid     = {s1_axis_valid, s0_axis_valid};
  assign src_last      = {s1_axis_last, s0_axis_last};
  assign src_data[0]   = s0_axis_data;
  assign src_data[1]   = s1_axis_data;
  assign s0_axis_ready = src_ready[0];
  assign s1_axis_ready = src_ready[1];

  // A source can start a frame only when it is presenting the first beat of
  // that frame.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign eligible[gi] = src_valid[gi] & ~in_frame_reg[gi];
    end
  endgenerate

  assign grant       = state_reg;
  assign frame_count = frame_count_reg;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    src_ready       = 2'b00;
    m_axis_valid    = 1'b0;
    m_axis_last     = 1'b0;
    m_axis_data     = '0;

    case (state_reg)
      IDLE: begin
        if (!mode) begin
          // The unselected source is drained. The selected source is held at a
          // frame start so its L beat waits for the grant. If the selected
          // source is stuck mid-frame (for example, after sel changed), its
          // remainder is drained so it can realign to a frame boundary instead
          // of deadlocking.
          src_ready[0] = sel ? 1'b1 : in_frame_reg[0];
          src_ready[1] = sel ? in_frame_reg[1] : 1'b1;
          if (eligible[sel]) begin
            state_next      = sel ? OWN1 : OWN0;
            last_grant_next = sel;
          end
        end else begin
          if (eligible[0] && (!eligible[1] || last_grant_reg)) begin
            state_next      = OWN0;
            last_grant_next = 1'b0;
          end else if (eligible[1]) begin
            state_next      = OWN1;
            last_grant_next = 1'b1;
          end
        end
      end

      OWN0: begin
        m_axis_valid = src_valid[0];
        m_axis_last  = src_last[0];
        m_axis_data  = mute_q_reg ? '0 : src_data[0];
        src_ready[0] = m_axis_ready;
        src_ready[1] = ~mode;
        if (src_valid[0] && m_axis_ready && src_last[0]) begin
          state_next = IDLE;
        end
      end

      OWN1: begin
        m_axis_valid = src_valid[1];
        m_axis_last  = src_last[1];
        m_axis_data  = mute_q_reg ? '0 : src_data[1];
        src_ready[1] = m_axis_ready;
        src_ready[0] = ~mode;
        if (src_valid[1] && m_axis_ready && src_last[1]) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Force every output quiet while reset is held, whatever the stale state.
    if (reset) begin
      src_ready    = 2'b00;
      m_axis_valid = 1'b0;
      m_axis_last  = 1'b0;
      m_axis_data  = '0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      mute_q_reg      <= 1'b0;
      frame_count_reg <= '0;
      in_frame_reg    <= 2'b00;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      // Mute takes effect only at a frame boundary, never inside a frame.
      if (state_reg == IDLE && state_next != IDLE) begin
        mute_q_reg <= mute;
      end
      if (m_axis_valid && m_axis_ready && m_axis_last) begin
        frame_count_reg <= frame_count_reg + 1'b1;
      end
      // Frame tracking counts every accepted beat, including drained ones.
      for (int i = 0; i < 2; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          in_frame_reg[i] <= ~src_last[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_arbiter
//
// Directed bench for axis_frame_arbiter. Scenarios queue source beats and push
// the master beats they expect into a scoreboard queue. A monitor pops the
// queue on every master handshake. Grant, ready and frame_count are checked
// inline at chosen cycles. The frame counter is built 8 bits wide so that the
// wrap from all-ones happens within a short run.
//
// Timing per clock period: source drivers pop at +1 after posedge. Scenario
// steps act at +2. Source drivers drive at +3. All sampling is on the negedge.
// -----------------------------------------------------------------------------
module tb_axis_frame_arbiter;

  localparam int DW = 24;
  localparam int FW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          mode, sel, mute;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic          s0_valid, s0_last, s0_ready;
  logic          s1_valid, s1_last, s1_ready;
  logic          m_valid, m_last, m_ready;
  logic [1:0]    grant;
  logic [FW-1:0] frame_count;

  beat_t         q0[$], q1[$], exp_q[$];
  logic [FW-1:0] exp_fc;
  int            n_checks, n_pass;
  logic          hs0, hs1;

  axis_frame_arbiter #(.DATA_WIDTH(DW), .FCNT_WIDTH(FW)) dut (
    .axis_clk     (clk),
    .reset        (reset),
    .mode         (mode),
    .sel          (sel),
    .mute         (mute),
    .s0_axis_data (s0_data),
    .s0_axis_valid(s0_valid),
    .s0_axis_last (s0_last),
    .s0_axis_ready(s0_ready),
    .s1_axis_data (s1_data),
    .s1_axis_valid(s1_valid),
    .s1_axis_last (s1_last),
    .s1_axis_ready(s1_ready),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_last  (m_last),
    .m_axis_ready (m_ready),
    .grant        (grant),
    .frame_count  (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Queue one L/R frame on a source. Optionally expect it on the master port,
  // with zeroed data if muted.
  task automatic push_frame(input int src, input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input bit expect_it, input bit muted);
    beat_t bl, br;
    bl = '{data: l, last: 1'b0};
    br = '{data: r, last: 1'b1};
    if (src == 0) begin q0.push_back(bl); q0.push_back(br); end
    else          begin q1.push_back(bl); q1.push_back(br); end
    if (expect_it) begin
      exp_q.push_back('{data: muted ? '0 : l, last: 1'b0});
      exp_q.push_back('{data: muted ? '0 : r, last: 1'b1});
      exp_fc++;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && grant == 2'b00) return;
      step();
    end
    n_checks++;
    $display("FAIL wait_idle: timeout after %0d cycles, q0=%0d q1=%0d exp=%0d grant=%b",
             budget, q0.size(), q1.size(), exp_q.size(), grant);
  endtask

  // Source drivers: present the head of each queue, pop after a handshake.
  initial begin
    hs0 = 1'b0; hs1 = 1'b0;
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      #2;
      s0_valid = (q0.size() > 0);
      s0_data  = (q0.size() > 0) ? q0[0].data : '0;
      s0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
      s1_valid = (q1.size() > 0);
      s1_data  = (q1.size() > 0) ? q1[0].data : '0;
      s1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
      @(negedge clk);
      hs0 = s0_valid & s0_ready;
      hs1 = s1_valid & s1_ready;
    end
  end

  // Scoreboard monitor: one line per master beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data 0x%06h last %0d, expected no beat", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          $display("beat: grant=%b data=0x%06h last=%0d (expect 0x%06h/%0d)",
                   grant, m_data, m_last, e.data, e.last);
          check("m_data", 32'(m_data), 32'(e.data));
          check("m_last", 32'(m_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    g_exp [8];
    logic [FW-1:0] fc_hold;
    int            n;
    n_checks = 0; n_pass = 0; exp_fc = '0;
    reset = 1'b1; mode = 1'b0; sel = 1'b0; mute = 1'b0; m_ready = 1'b1;

    // ---- reset state ----
    step(); step();
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s0_ready", 32'(s0_ready), 32'd0);
    check("rst_s1_ready", 32'(s1_ready), 32'd0);
    step();
    reset = 1'b0;
    step();

    // ---- fixed select, sel=0: only s0 pairs reach the master, s1 is drained ----
    for (int i = 0; i < 3; i++) begin
      push_frame(0, 24'h000111, 24'h000222, 1'b1, 1'b0);
      push_frame(1, 24'h000333, 24'h000444, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("fix_idle_grant", 32'(grant), 32'd0);
    check("fix_sel_held", 32'(s0_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("fix_s1_flush", 32'(s1_ready), 32'd1);
      step();
      @(negedge clk);
    end
    step();
    wait_idle(40);
    check("fix_fc", 32'(frame_count), 32'(exp_fc));

    // ---- sel toggled mid-frame: no preemption, s1 realigns on its next L ----
    push_frame(0, 24'h000555, 24'h000666, 1'b1, 1'b0);
    push_frame(1, 24'h000771, 24'h000881, 1'b0, 1'b0);
    push_frame(1, 24'h000772, 24'h000882, 1'b0, 1'b0);
    push_frame(1, 24'h000773, 24'h000883, 1'b1, 1'b0);
    step();                       // s0 L on master
    step(); sel = 1'b1;           // s0 R still owns the bus
    @(negedge clk);
    check("sel_no_preempt", 32'(grant), 32'b01);
    step();
    @(negedge clk);
    check("sel_idle", 32'(grant), 32'b00);
    check("sel_partial_flush", 32'(s1_ready), 32'd1);
    step();
    @(negedge clk);
    check("sel_l_held", 32'(s1_ready), 32'd0);
    step();
    @(negedge clk);
    check("sel_grant_s1", 32'(grant), 32'b10);
    step();
    wait_idle(40);
    check("sel_fc", 32'(frame_count), 32'(exp_fc));

    // ---- round-robin, both sources loaded ----
    mode = 1'b1;
    push_frame(0, 24'h000010, 24'h000020, 1'b1, 1'b0);
    push_frame(1, 24'h000A10, 24'h000A20, 1'b1, 1'b0);
    push_frame(0, 24'h000011, 24'h000021, 1'b1, 1'b0);
    push_frame(1, 24'h000A11, 24'h000A21, 1'b1, 1'b0);
    g_exp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("rr_grant[%0d]", i), 32'(grant), 32'(g_exp[i]));
      if (i == 0) check("rr_idle_s0_ready", 32'(s0_ready), 32'd0);
      if (i == 1) check("rr_s1_stalled", 32'(s1_ready), 32'd0);
      if (i == 4) check("rr_s0_stalled", 32'(s0_ready), 32'd0);
      step();
    end
    wait_idle(40);
    check("rr_fc", 32'(frame_count), 32'(exp_fc));

    // ---- mute raised mid-frame: applies from the next frame ----
    push_frame(0, 24'h0000AA, 24'h0000BB, 1'b1, 1'b0);
    push_frame(0, 24'h0000CC, 24'h0000DD, 1'b1, 1'b1);
    step();
    step(); mute = 1'b1;
    wait_idle(40);
    mute = 1'b0;
    check("mute_fc", 32'(frame_count), 32'(exp_fc));

    // ---- back-pressure for 5 cycles on the R beat ----
    fc_hold = exp_fc;
    push_frame(1, 24'h000E01, 24'h000E02, 1'b1, 1'b0);
    step();
    step(); m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_data", 32'(m_data), 32'h000E02);
      check("bp_fc", 32'(frame_count), 32'(fc_hold));
      check("bp_s1_ready", 32'(s1_ready), 32'd0);
      step();
    end
    m_ready = 1'b1;
    wait_idle(40);
    check("bp_fc_after", 32'(frame_count), 32'(exp_fc));

    // ---- frame counter reaches all-ones, then wraps ----
    n = 255 - int'(exp_fc);
    for (int i = 0; i < n; i++) begin
      push_frame(0, 24'h100000 + DW'(i), 24'h200000 + DW'(i), 1'b1, 1'b0);
    end
    wait_idle(1000);
    check("fc_all_ones", 32'(frame_count), 32'hFF);
    push_frame(0, 24'h000123, 24'h000456, 1'b1, 1'b0);
    wait_idle(40);
    check("fc_wrap", 32'(frame_count), 32'(exp_fc));

    // ---- reset mid-frame: L beat delivered, R beat abandoned ----
    q0.push_back('{data: 24'h00F0F0, last: 1'b0});
    q0.push_back('{data: 24'h00F1F1, last: 1'b1});
    exp_q.push_back('{data: 24'h00F0F0, last: 1'b0});
    step();                       // L on master
    step(); reset = 1'b1;         // R presented while reset held
    @(negedge clk);
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_m_last", 32'(m_last), 32'd0);
    check("mrst_m_data", 32'(m_data), 32'd0);
    check("mrst_s0_ready", 32'(s0_ready), 32'd0);
    check("mrst_s1_ready", 32'(s1_ready), 32'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    check("mrst_grant", 32'(grant), 32'd0);
    check("mrst_fc", 32'(frame_count), 32'd0);
    check("mrst_no_early_grant", 32'(m_valid), 32'd0);
    // The stranded R beat is now a fresh one-beat frame.
    exp_fc = '0;
    exp_q.push_back('{data: 24'h00F1F1, last: 1'b1});
    exp_fc++;
    step();
    wait_idle(40);
    check("mrst_fc_after", 32'(frame_count), 32'(exp_fc));

    step(); step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
